// File: rtl/enc_pkg.sv
// Shared constants and helpers for the registered priority encoder.
package enc_pkg;

  // Width and saturation ceiling of the error counter.
  localparam int ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_ONE = 8'd1;

  // Saturating increment: the counter sticks at its ceiling instead of wrapping.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    logic [ERR_CNT_W-1:0] r;
    if (v == ERR_CNT_MAX) begin
      r = v;
    end else begin
      r = v + ERR_CNT_ONE;
    end
    return r;
  endfunction

endpackage

// File: rtl/enc_core.sv
// Purely combinational priority encoder: winning index plus multi-hot and
// all-zero flags, so the caller can decide what counts as an error.
module enc_core #(
  parameter int N         = 8,
  parameter int W         = $clog2(N),
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic [N-1:0] in_vec,
  output logic [W-1:0] code,
  output logic         multi,
  output logic         zero
);

  logic w_seen;

  // Scan so that the last set bit visited is the winner: ascending order for
  // highest-wins, descending order for lowest-wins.
  always_comb begin
    code   = '0;
    multi  = 1'b0;
    w_seen = 1'b0;
    for (int i = 0; i < N; i++) begin
      int idx;
      idx    = MSB_FIRST ? i : (N - 1 - i);
      code   = in_vec[idx] ? W'(idx) : code;
      multi  = multi | (w_seen & in_vec[idx]);
      w_seen = w_seen | in_vec[idx];
    end
  end

  assign zero = ~|in_vec;

endmodule

// File: rtl/priority_encoder_reg.sv
// Registered priority encoder with a one-deep valid/ready result stage and a
// saturating counter of accepted error words.
module priority_encoder_reg
  import enc_pkg::*;
#(
  parameter int N         = 8,
  parameter int W         = $clog2(N),
  parameter bit MSB_FIRST = 1'b1,
  parameter bit STRICT    = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_vec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_code,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 clr_err
);

  logic                 r_valid;
  logic                 r_err;
  logic [W-1:0]         r_code;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  logic [W-1:0] w_code;
  logic         w_multi;
  logic         w_zero;
  logic         w_err;
  logic         w_in_xfer;
  logic         w_out_xfer;

  enc_core #(
    .N         (N),
    .W         (W),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .in_vec (in_vec),
    .code   (w_code),
    .multi  (w_multi),
    .zero   (w_zero)
  );

  // All-zero words are always invalid; multi-hot words only in strict mode.
  assign w_err      = w_zero | (STRICT & w_multi);
  assign in_ready   = ~r_valid | out_ready;
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = r_valid & out_ready;

  // Result register: load on accept, drop valid once drained; an error word
  // keeps the last good code on out_code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_code  <= '0;
    end else if (w_in_xfer) begin
      r_valid <= 1'b1;
      r_err   <= w_err;
      if (!w_err) begin
        r_code <= w_code;
      end else begin
        r_code <= r_code;
      end
    end else if (w_out_xfer) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  // Error counter: a clear that coincides with an error word still counts that word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (w_in_xfer && w_err) begin
      r_err_cnt <= clr_err ? ERR_CNT_ONE : sat_inc(r_err_cnt);
    end else if (clr_err) begin
      r_err_cnt <= '0;
    end else begin
      r_err_cnt <= r_err_cnt;
    end
  end

  assign out_valid = r_valid;
  assign out_code  = r_code;
  assign out_err   = r_err;
  assign err_count = r_err_cnt;

endmodule
